// File: rtl/mod_pkg.sv
// Shared modular-arithmetic definitions.
// Default datapath width for mod_differentiator and mod_accumulator.
package mod_pkg;
  localparam int unsigned MOD_BITWIDTH = 32;
endpackage

// File: rtl/mod_sub.sv
// Combinational modular subtract: oDiff = (iX - iY) mod iMod.
// Ports: iX, iY, iMod in; oDiff result, oOor set when iX >= iMod.
module mod_sub
  import mod_pkg::*;
#(
  parameter int unsigned BITWIDTH = MOD_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] iX,
  input  logic [BITWIDTH-1:0] iY,
  input  logic [BITWIDTH-1:0] iMod,
  output logic [BITWIDTH-1:0] oDiff,
  output logic                oOor
);

  logic [BITWIDTH:0] sub_w;

  always_comb begin
    sub_w = {1'b0, iX} - {1'b0, iY};
    // top bit is the borrow: x < y, so fold back by adding M
    if (sub_w[BITWIDTH]) begin
      oDiff = sub_w[BITWIDTH-1:0] + iMod;
    end else begin
      oDiff = sub_w[BITWIDTH-1:0];
    end
    oOor = (iX >= iMod);
  end

endmodule

// File: rtl/mod_differentiator.sv
// Recovers per-step increments from a stream of accumulated residues.
// Ports: iClk/iRstN/iClr; in beat iValid/oReady/iData/iMod; out beat oValid/iReady/oData/oErr.
module mod_differentiator
  import mod_pkg::*;
#(
  parameter int unsigned BITWIDTH = MOD_BITWIDTH
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  logic [BITWIDTH-1:0] prev_q, prev_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [BITWIDTH-1:0] diff;
  logic                oor;
  logic                accept;

  mod_sub #(
    .BITWIDTH(BITWIDTH)
  ) u_sub (
    .iX   (iData),
    .iY   (prev_q),
    .iMod (iMod),
    .oDiff(diff),
    .oOor (oor)
  );

  // gated by reset so the block reports not-ready while held in reset
  assign oReady = iRstN & (~valid_q | iReady) & ~iClr;
  assign accept = iValid & oReady;

  always_comb begin
    prev_d  = prev_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (iClr) begin
      prev_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      err_d   = oor;
      data_d  = oor ? '0 : diff;
      // an out-of-range residue must not poison the history
      prev_d  = oor ? prev_q : iData;
    end else if (iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oErr   = err_q;

endmodule

// File: tb/tb_mod_differentiator.sv
// Directed bench for mod_differentiator with a queue-based reference model.
// Checks every output cycle plus literal expectations per scenario.
module tb_mod_differentiator;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready_dut;
  logic [31:0] in_data;
  logic [31:0] in_mod;
  logic        out_valid;
  logic        ds_ready;
  logic [31:0] out_data;
  logic        out_err;

  int nvec = 0;
  int nerr = 0;
  int stalls = 0;

  logic [32:0] expq[$];
  logic [31:0] got_d[$];
  logic        got_e[$];
  longint unsigned mprev = 0;

  mod_differentiator #(.BITWIDTH(32)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .iClr  (clr),
    .iValid(in_valid),
    .oReady(out_ready_dut),
    .iData (in_data),
    .iMod  (in_mod),
    .oValid(out_valid),
    .iReady(ds_ready),
    .oData (out_data),
    .oErr  (out_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input longint unsigned x,
                                        input longint unsigned m,
                                        input longint unsigned p);
    longint unsigned d;
    if (x >= m) return {1'b1, 32'd0};
    if (x >= p) d = x - p;
    else d = (x + m - p) & 64'hFFFF_FFFF;
    return {1'b0, d[31:0]};
  endfunction

  // reference model and per-cycle compare, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      mprev = 0;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_ready", {63'd0, out_ready_dut}, 64'd0);
    end else begin
      chk("ready", {63'd0, out_ready_dut},
          {63'd0, (!out_valid || ds_ready) && !clr});
      chk("valid", {63'd0, out_valid}, {63'd0, expq.size() != 0});
      if (out_valid && expq.size() != 0) begin
        chk("data", {32'd0, out_data}, {32'd0, expq[0][31:0]});
        chk("err", {63'd0, out_err}, {63'd0, expq[0][32]});
        if (ds_ready && !clr) begin
          got_d.push_back(out_data);
          got_e.push_back(out_err);
          void'(expq.pop_front());
        end
      end
      if (clr) begin
        expq.delete();
        mprev = 0;
      end else if (in_valid && out_ready_dut) begin
        expq.push_back(model(in_data, in_mod, mprev));
        if (in_data < in_mod) mprev = in_data;
      end
    end
  end

  task automatic beat(input logic [31:0] x, input logic [31:0] m);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = x;
    in_mod = m;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (out_ready_dut) ok = 1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_clr();
    in_valid = 0;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int idx,
                         input logic [31:0] d, input logic e);
    if (idx < got_d.size()) begin
      chk(nm, {32'd0, got_d[idx]}, {32'd0, d});
      chk(nm, {63'd0, got_e[idx]}, {63'd0, e});
    end else begin
      chk(nm, 64'd0, 64'd1);
    end
  endtask

  initial begin
    rst_n = 0;
    clr = 0;
    in_valid = 0;
    in_data = 0;
    in_mod = 0;
    ds_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset_oValid", {63'd0, out_valid}, 64'd0);
    chk("reset_oData", {32'd0, out_data}, 64'd0);
    chk("reset_oErr", {63'd0, out_err}, 64'd0);
    chk("reset_oReady", {63'd0, out_ready_dut}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1;

    // accumulated stream of +10 mod 13
    got_d.delete(); got_e.delete();
    stalls = 0;
    beat(10, 13); beat(7, 13); beat(4, 13);
    beat(1, 13); beat(11, 13); beat(8, 13);
    drain();
    chk("stream_stalls", stalls, 0);
    chk("stream_count", got_d.size(), 6);
    for (int i = 0; i < 6; i++) chk_out("stream_out", i, 32'd10, 1'b0);

    // backpressure
    do_clr();
    got_d.delete(); got_e.delete();
    ds_ready = 0;
    beat(3, 13);
    in_valid = 1; in_data = 5; in_mod = 13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", {63'd0, out_ready_dut}, 64'd0);
      chk("bp_hold", {32'd0, out_data}, 64'd3);
      @(posedge clk);
      #1;
    end
    ds_ready = 1;
    beat(5, 13);
    drain();
    chk("bp_count", got_d.size(), 2);
    chk_out("bp_out0", 0, 32'd3, 1'b0);
    chk_out("bp_out1", 1, 32'd2, 1'b0);

    // out-of-range input leaves history alone
    do_clr();
    got_d.delete(); got_e.delete();
    beat(4, 13); beat(13, 13); beat(6, 13);
    drain();
    chk_out("err_out0", 0, 32'd4, 1'b0);
    chk_out("err_out1", 1, 32'd0, 1'b1);
    chk_out("err_out2", 2, 32'd2, 1'b0);

    // clear beats a simultaneous input and a pending output
    do_clr();
    ds_ready = 0;
    beat(2, 13);
    got_d.delete(); got_e.delete();
    clr = 1; in_valid = 1; in_data = 9; in_mod = 13;
    @(negedge clk);
    chk("clr_ready", {63'd0, out_ready_dut}, 64'd0);
    @(posedge clk);
    #1;
    clr = 0; in_valid = 0;
    chk("clr_valid", {63'd0, out_valid}, 64'd0);
    ds_ready = 1;
    beat(5, 13);
    drain();
    chk("clr_count", got_d.size(), 1);
    chk_out("clr_out", 0, 32'd5, 1'b0);

    // full-width wrap
    do_clr();
    got_d.delete(); got_e.delete();
    beat(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    beat(32'h0000_0001, 32'hFFFF_FFFF);
    drain();
    chk_out("wrap_out0", 0, 32'hFFFF_FFFE, 1'b0);
    chk_out("wrap_out1", 1, 32'h0000_0002, 1'b0);

    // M=1, M=0, and a shrinking modulus below prev
    do_clr();
    got_d.delete(); got_e.delete();
    beat(0, 1); beat(0, 0); beat(10, 13); beat(2, 5);
    drain();
    chk_out("m1_out", 0, 32'd0, 1'b0);
    chk_out("m0_out", 1, 32'd0, 1'b1);
    chk_out("mchg_out0", 2, 32'd10, 1'b0);
    chk_out("mchg_out1", 3, 32'hFFFF_FFFD, 1'b0);

    // asynchronous reset mid-stream
    do_clr();
    ds_ready = 0;
    beat(4, 13);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_ready", {63'd0, out_ready_dut}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    ds_ready = 1;
    got_d.delete(); got_e.delete();
    stalls = 0;
    beat(7, 13);
    drain();
    chk("arst_stalls", stalls, 0);
    chk("arst_count", got_d.size(), 1);
    chk_out("arst_out", 0, 32'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mod_differentiator.md
MOD_DIFFERENTIATOR -- requirements
Module: mod_differentiator

Interface
REQ-001 Parameter: BITWIDTH, default 32, width of data, modulus and result.
REQ-002 iClk  input  1  sole clock; all state updates on rising edge.
REQ-003 iRstN  input  1  asynchronous, active-low reset.
REQ-004 iClr  input  1  synchronous clear of history and pending output.
REQ-005 iValid  input  1  input beat valid.
REQ-006 oReady  output  1  block can accept an input beat.
REQ-007 iData  input  BITWIDTH  accumulated residue x[n], expected in [0, iMod-1].
REQ-008 iMod  input  BITWIDTH  modulus M, sampled with each accepted beat.
REQ-009 oValid  output  1  output beat valid.
REQ-010 iReady  input  1  downstream accepts output beat.
REQ-011 oData  output  BITWIDTH  recovered increment (x[n] - x[n-1]) mod M.
REQ-012 oErr  output  1  flags the current output beat as derived from an out-of-range input.

Function
REQ-013 The block SHALL invert mod_accumulator: it emits the per-step increment from a stream of accumulated residues.
REQ-014 The history register prev SHALL hold the last in-range accepted iData; after reset or clear, prev = 0, so the first output equals x[0].
REQ-015 An input beat SHALL be accepted on a rising edge with iValid=1, oReady=1 and iClr=0.
REQ-016 oReady SHALL equal (!oValid || iReady) && !iClr, giving a one-entry output register with full-throughput pass-through.
REQ-017 Latency SHALL be 1 cycle: an accepted beat appears on oData/oValid in the following cycle; back-to-back beats sustain 1 beat/cycle when iReady=1.
REQ-018 Arithmetic SHALL use BITWIDTH+1 bits: if x >= prev, result = x - prev; otherwise result = x - prev + M; the result is truncated to BITWIDTH and is always < M.
REQ-019 If iData >= iMod (including iMod = 0), the beat SHALL still be accepted and produce oData = 0 and oErr = 1; prev SHALL NOT update.
REQ-020 For in-range beats, oErr SHALL be 0 and prev <= iData.
REQ-021 With iMod = 1, every in-range beat SHALL produce oData = 0.
REQ-022 oData/oErr SHALL hold stable while oValid=1 and iReady=0; oValid SHALL drop only after a cycle with iReady=1 and no new accept.
REQ-023 A change of iMod between beats is permitted; if prev >= the new M, output is the REQ-018 formula result unchecked (no error flag).
REQ-024 iClr=1 SHALL on the next edge set prev = 0, oValid = 0, oErr = 0, discard any pending output, and accept no input in that cycle.
REQ-025 iClr SHALL take priority over a simultaneous input beat and over a simultaneous output handshake.

Reset
REQ-026 While iRstN=0: prev = 0, oValid = 0, oData = 0, oErr = 0, and oReady = 0.
REQ-027 The first accept SHALL be possible on the first rising edge after iRstN deasserts.
REQ-028 Reset asserted mid-stream SHALL drop the pending output immediately, without waiting for a clock edge.

Structure
REQ-029 Shared package mod_pkg SHALL hold the default BITWIDTH constant and any shared modular-arithmetic functions, also usable by mod_accumulator.
REQ-030 The modular subtraction SHALL be a combinational sub-module mod_sub (x, y, M -> (x - y) mod M, out-of-range flag), instantiated once.
REQ-031 Implementation: prev register, output register, and handshake logic; no other state.

Verification
REQ-032 Mod stream: M=13, iReady=1, inputs 10,7,4,1,11,8 (mod_accumulator output for iData=10) -> outputs 10,10,10,10,10,10, oErr=0, 1 beat/cycle.
REQ-033 Backpressure: M=13, inputs 3,5 with iReady=0 for 3 cycles -> oData=3 held stable, oReady=0; after release outputs 3 then 2, no loss or duplication.
REQ-034 Error: M=13, prev=4, input 13 -> oData=0, oErr=1; next input 6 -> oData=2 (prev still 4).
REQ-035 Clear: pending oValid=1, then iClr=1 with iValid=1 and input 9 -> oValid=0, input dropped; next input 5 -> oData=5.
REQ-036 Wrap/width: BITWIDTH=32, M=0xFFFFFFFF, inputs 0xFFFFFFFE then 0x00000001 -> outputs 0xFFFFFFFE, then 0x00000002 with no overflow.
REQ-037 Async reset: assert iRstN=0 mid-stream between clock edges -> oValid=0 immediately; after release, first input 7 (M=13) -> oData=7.
